// File: rtl/dtm_uart_pkg.sv
// Shared definitions for the host side of the UART debug link: frame constants,
// DMI op/resp codes, FSM state encoding and the packed request/response layouts.
package dtm_uart_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'h5A;
  localparam int         REQ_FRAME_LEN  = 7;
  localparam int         RESP_FRAME_LEN = 5;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [1:0] RESP_SUCCESS = 2'd0;
  localparam logic [1:0] RESP_FAILED  = 2'd2;
  localparam logic [1:0] RESP_BUSY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  op;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // Byte idx of the outgoing request frame.
  function automatic logic [7:0] req_frame_byte(input dmi_req_t req, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = {6'b0, req.op};
      3'd2:    b = {1'b0, req.addr};
      3'd3:    b = req.data[7:0];
      3'd4:    b = req.data[15:8];
      3'd5:    b = req.data[23:16];
      default: b = req.data[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmi_uart_host_timeout.sv
// Idle-RX watchdog for WAIT_RESP: counts cycles without a received byte and
// flags expiry; a byte in the expiry cycle (clr) suppresses the flag.
module dmi_uart_host_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (!en || clr) begin
      count_q <= '0;
    end else if (count_q != LAST) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = en && !clr && (count_q == LAST);

endmodule

// File: rtl/dmi_uart_host.sv
// DMI request -> 7-byte UART frame, 5-byte reply -> DMI response.
// Optional RX timeout in WAIT_RESP enabled by defining DMI_UART_HOST_TIMEOUT_EN.
import dtm_uart_pkg::*;

module dmi_uart_host #(
  parameter int unsigned CLOCK_HZ       = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = CLOCK_HZ / 1000
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        REQ_VALID_I,
  output logic        REQ_READY_O,
  input  logic [40:0] REQ_I,
  output logic        RESP_VALID_O,
  input  logic        RESP_READY_I,
  output logic [33:0] RESP_O,
  output logic [7:0]  TX_DATA_O,
  output logic        TX_VALID_O,
  input  logic        TX_READY_I,
  input  logic [7:0]  RX_DATA_I,
  input  logic        RX_VALID_I,
  output logic        STRAY_O,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid, once raised, holds its payload stable until that edge.

  localparam logic [2:0] TX_LAST = 3'(REQ_FRAME_LEN - 1);
  localparam logic [2:0] RX_LAST = 3'(RESP_FRAME_LEN - 1);

  state_e      state_q;
  dmi_req_t    req_q;
  dmi_req_t    req_in;
  logic [2:0]  tx_idx_q;
  logic [2:0]  rx_idx_q;
  logic [31:0] rx_data_q;
  logic        timeout_expire;

  assign req_in    = REQ_I;
  assign dbg_state = state_q;

`ifdef DMI_UART_HOST_TIMEOUT_EN
  dmi_uart_host_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK_I),
    .rst    (RST_I),
    .en     (state_q == ST_WAIT_RESP),
    .clr    (RX_VALID_I),
    .expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      tx_idx_q     <= '0;
      rx_idx_q     <= '0;
      rx_data_q    <= '0;
      REQ_READY_O  <= 1'b0;
      RESP_VALID_O <= 1'b0;
      RESP_O       <= '0;
      TX_VALID_O   <= 1'b0;
      TX_DATA_O    <= '0;
      STRAY_O      <= 1'b0;
    end else begin
      STRAY_O <= RX_VALID_I && (state_q != ST_WAIT_RESP);
      case (state_q)
        ST_IDLE: begin
          REQ_READY_O <= 1'b1;
          if (REQ_VALID_I && REQ_READY_O) begin
            REQ_READY_O <= 1'b0;
            req_q       <= req_in;
            case (req_in.op)
              OP_READ, OP_WRITE: begin
                state_q    <= ST_SEND;
                tx_idx_q   <= '0;
                TX_VALID_O <= 1'b1;
                TX_DATA_O  <= SYNC_BYTE;
              end
              OP_NOP: begin
                state_q      <= ST_RESP;
                RESP_VALID_O <= 1'b1;
                RESP_O       <= {32'b0, RESP_SUCCESS};
              end
              default: begin
                state_q      <= ST_RESP;
                RESP_VALID_O <= 1'b1;
                RESP_O       <= {32'b0, RESP_FAILED};
              end
            endcase
          end
        end
        ST_SEND: begin
          if (TX_VALID_O && TX_READY_I) begin
            if (tx_idx_q == TX_LAST) begin
              TX_VALID_O <= 1'b0;
              rx_idx_q   <= '0;
              state_q    <= ST_WAIT_RESP;
            end else begin
              tx_idx_q  <= tx_idx_q + 3'd1;
              TX_DATA_O <= req_frame_byte(req_q, tx_idx_q + 3'd1);
            end
          end
        end
        ST_WAIT_RESP: begin
          // Data bytes land LSB first; the status byte goes straight to RESP_O.
          if (RX_VALID_I) begin
            if (rx_idx_q == RX_LAST) begin
              rx_idx_q     <= '0;
              state_q      <= ST_RESP;
              RESP_VALID_O <= 1'b1;
              RESP_O       <= {rx_data_q, RX_DATA_I[1:0]};
            end else begin
              rx_data_q[{rx_idx_q[1:0], 3'b000} +: 8] <= RX_DATA_I;
              rx_idx_q <= rx_idx_q + 3'd1;
            end
          end else if (timeout_expire) begin
            rx_idx_q     <= '0;
            state_q      <= ST_RESP;
            RESP_VALID_O <= 1'b1;
            RESP_O       <= {32'b0, RESP_FAILED};
          end
        end
        ST_RESP: begin
          if (RESP_READY_I) begin
            RESP_VALID_O <= 1'b0;
            REQ_READY_O  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_uart_host.sv
// Self-checking bench for dmi_uart_host: TX bytes and DMI responses are compared
// against scoreboard queues filled when requests and replies are driven.
module tb_dmi_uart_host;
  import dtm_uart_pkg::*;

  localparam int unsigned TO_CYCLES = 16;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        REQ_VALID_I;
  logic        REQ_READY_O;
  logic [40:0] REQ_I;
  logic        RESP_VALID_O;
  logic        RESP_READY_I;
  logic [33:0] RESP_O;
  logic [7:0]  TX_DATA_O;
  logic        TX_VALID_O;
  logic        TX_READY_I;
  logic [7:0]  RX_DATA_I;
  logic        RX_VALID_I;
  logic        STRAY_O;
  logic [1:0]  dbg_state;

  dmi_uart_host #(
    .CLOCK_HZ       (100000000),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .REQ_VALID_I  (REQ_VALID_I),
    .REQ_READY_O  (REQ_READY_O),
    .REQ_I        (REQ_I),
    .RESP_VALID_O (RESP_VALID_O),
    .RESP_READY_I (RESP_READY_I),
    .RESP_O       (RESP_O),
    .TX_DATA_O    (TX_DATA_O),
    .TX_VALID_O   (TX_VALID_O),
    .TX_READY_I   (TX_READY_I),
    .RX_DATA_I    (RX_DATA_I),
    .RX_VALID_I   (RX_VALID_I),
    .STRAY_O      (STRAY_O),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 CLK_I = ~CLK_I;
  int cyc = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  // Scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  tx_exp_q[$];
  logic [33:0] resp_exp_q[$];
  int          tx_acc_cyc[$];
  int          stray_cnt = 0;
  int          resp_rise_cyc = -1;
  logic        resp_valid_prev = 1'b0;
  logic        resp_ready_prev = 1'b0;
  logic [33:0] resp_prev = '0;
  logic        held = 1'b0;
  logic [7:0]  held_byte = '0;
  logic        tx_toggle = 1'b0;
  logic        tx_ready_fix = 1'b1;
  bit          done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // TX ready driver: fixed level or toggling every cycle
  initial begin
    TX_READY_I = 1'b1;
    forever begin
      @(posedge CLK_I);
      #2;
      if (tx_toggle) TX_READY_I = ~TX_READY_I;
      else           TX_READY_I = tx_ready_fix;
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge CLK_I) begin
    if (RST_I) begin
      held = 1'b0;
      resp_valid_prev = 1'b0;
      resp_ready_prev = 1'b0;
    end else begin
      if (STRAY_O) stray_cnt++;
      if (held) begin
        check("tx_hold_valid", TX_VALID_O, 1);
        check("tx_hold_data", TX_DATA_O, held_byte);
      end
      held = TX_VALID_O && !TX_READY_I;
      held_byte = TX_DATA_O;
      if (TX_VALID_O && TX_READY_I) begin
        check("tx_expected", tx_exp_q.size() != 0, 1);
        if (tx_exp_q.size() != 0) check("tx_byte", TX_DATA_O, tx_exp_q.pop_front());
        tx_acc_cyc.push_back(cyc);
      end
      if (resp_valid_prev && !resp_ready_prev) begin
        check("resp_hold_valid", RESP_VALID_O, 1);
        check("resp_hold_data", RESP_O, resp_prev);
      end
      if (RESP_VALID_O && !resp_valid_prev) resp_rise_cyc = cyc;
      if (RESP_VALID_O && RESP_READY_I) begin
        check("resp_expected", resp_exp_q.size() != 0, 1);
        if (resp_exp_q.size() != 0) check("resp_data", RESP_O, resp_exp_q.pop_front());
      end
      resp_valid_prev = RESP_VALID_O;
      resp_ready_prev = RESP_READY_I;
      resp_prev = RESP_O;
    end
  end

  // Driver tasks
  task automatic push_frame(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    logic [55:0] frame;
    frame = {data, 1'b0, addr, 6'b0, op, 8'h5A};
    for (int i = 0; i < 7; i++) tx_exp_q.push_back(frame[8*i +: 8]);
  endtask

  task automatic send_req(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          output int hs);
    bit ok;
    ok = 1'b0;
    @(posedge CLK_I);
    #1;
    REQ_VALID_I = 1'b1;
    REQ_I = {addr, data, op};
    if (op == OP_READ || op == OP_WRITE) push_frame(op, addr, data);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_I);
      if (REQ_READY_O) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_accepted", ok, 1);
    @(posedge CLK_I);
    #1;
    hs = cyc;
    REQ_VALID_I = 1'b0;
  endtask

  task automatic wait_tx_done();
    for (int i = 0; i < 200 && tx_exp_q.size() != 0; i++) @(posedge CLK_I);
    #1;
    check("tx_frame_done", tx_exp_q.size() == 0, 1);
  endtask

  task automatic wait_resp_done();
    for (int i = 0; i < 200 && resp_exp_q.size() != 0; i++) @(negedge CLK_I);
    check("resp_done", resp_exp_q.size() == 0, 1);
  endtask

  // Drives n reply bytes, one per cycle, once the DUT waits for a reply.
  task automatic send_reply(input logic [39:0] bytes, input int n, input logic [33:0] exp,
                            output int last_cyc);
    bit ok;
    ok = 1'b0;
    resp_exp_q.push_back(exp);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK_I);
      if (dbg_state == ST_WAIT_RESP) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_wait_resp", ok, 1);
    for (int i = 0; i < n; i++) begin
      RX_VALID_I = 1'b1;
      RX_DATA_I = bytes[8*i +: 8];
      @(posedge CLK_I);
      #1;
      last_cyc = cyc;
    end
    RX_VALID_I = 1'b0;
  endtask

  initial begin
    #500000;
    if (!done) begin
      errors++;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    int hs;
    int last;
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [7:0]  status;

    RST_I = 1'b1;
    REQ_VALID_I = 1'b0;
    REQ_I = '0;
    RESP_READY_I = 1'b1;
    RX_VALID_I = 1'b0;
    RX_DATA_I = '0;

    repeat (2) @(posedge CLK_I);
    #1;
    check("rst_outputs", {REQ_READY_O, RESP_VALID_O, RESP_O, TX_VALID_O, TX_DATA_O, STRAY_O}, 0);
    check("rst_state", dbg_state, ST_IDLE);
    RST_I = 1'b0;
    @(posedge CLK_I);
    @(negedge CLK_I);
    check("req_ready_after_rst", REQ_READY_O, 1);

    // Write 0x10 <- 0xDEADBEEF, gapless burst, response held under backpressure
    tx_acc_cyc.delete();
    send_req(OP_WRITE, 7'h10, 32'hDEADBEEF, hs);
    wait_tx_done();
    check("tx_first_latency", tx_acc_cyc[0], hs);
    check("tx_burst_gapless", tx_acc_cyc[6] - tx_acc_cyc[0], 6);
    RESP_READY_I = 1'b0;
    send_reply(40'h00_DEADBEEF, 5, {32'hDEADBEEF, 2'd0}, last);
    repeat (3) @(negedge CLK_I);
    check("resp_rise_latency", resp_rise_cyc, last);
    RESP_READY_I = 1'b1;
    wait_resp_done();
    @(negedge CLK_I);
    check("req_ready_after_resp", REQ_READY_O, 1);

    // Read 0x11 with TX_READY toggling
    tx_toggle = 1'b1;
    send_req(OP_READ, 7'h11, 32'h0, hs);
    wait_tx_done();
    tx_toggle = 1'b0;
    send_reply(40'h03_12345678, 5, {32'h12345678, 2'd3}, last);
    wait_resp_done();

    // nop and reserved ops answer next cycle without UART traffic
    resp_rise_cyc = -1;
    resp_exp_q.push_back({32'h0, 2'd0});
    send_req(OP_NOP, 7'h05, 32'hFFFF_FFFF, hs);
    wait_resp_done();
    check("nop_latency", resp_rise_cyc, hs);
    resp_rise_cyc = -1;
    resp_exp_q.push_back({32'h0, 2'd2});
    send_req(OP_RSVD, 7'h06, 32'h1234_5678, hs);
    wait_resp_done();
    check("rsvd_latency", resp_rise_cyc, hs);

    // Stray RX byte in IDLE, then a read must still parse
    @(posedge CLK_I);
    #1;
    RX_VALID_I = 1'b1;
    RX_DATA_I = 8'h55;
    @(posedge CLK_I);
    #1;
    RX_VALID_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    check("stray_pulse", stray_cnt, 1);
    send_req(OP_READ, 7'h22, 32'h0, hs);
    wait_tx_done();
    send_reply(40'h00_CAFEF00D, 5, {32'hCAFEF00D, 2'd0}, last);
    wait_resp_done();

    // Random transactions
    for (int k = 0; k < 6; k++) begin
      op = 2'($urandom_range(1, 2));
      addr = 7'($urandom_range(0, 127));
      data = $urandom;
      rdata = $urandom;
      status = 8'($urandom_range(0, 255));
      tx_toggle = 1'($urandom_range(0, 1));
      send_req(op, addr, data, hs);
      wait_tx_done();
      tx_toggle = 1'b0;
      send_reply({status, rdata}, 5, {rdata, status[1:0]}, last);
      wait_resp_done();
    end

`ifdef DMI_UART_HOST_TIMEOUT_EN
    // Partial reply: timeout answers with failed, TO_CYCLES after last byte
    resp_rise_cyc = -1;
    send_req(OP_READ, 7'h33, 32'h0, hs);
    wait_tx_done();
    send_reply(40'h00_0000BEEF, 2, {32'h0, 2'd2}, last);
    wait_resp_done();
    check("timeout_latency", resp_rise_cyc, last + int'(TO_CYCLES));
`endif

    // Reset in the middle of a frame
    tx_acc_cyc.delete();
    send_req(OP_WRITE, 7'h05, 32'h0BAD_F00D, hs);
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK_I);
      #1;
      if (tx_acc_cyc.size() >= 3) break;
    end
    check("tx_before_rst", tx_acc_cyc.size(), 3);
    RST_I = 1'b1;
    #1;
    check("midframe_rst_outputs",
          {REQ_READY_O, RESP_VALID_O, RESP_O, TX_VALID_O, TX_DATA_O, STRAY_O}, 0);
    check("midframe_rst_state", dbg_state, ST_IDLE);
    tx_exp_q.delete();
    repeat (2) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    tx_acc_cyc.delete();
    send_req(OP_WRITE, 7'h44, 32'hA5A5_0F0F, hs);
    wait_tx_done();
    check("post_rst_frame_len", tx_acc_cyc.size(), 7);
    send_reply(40'h00_A5A50F0F, 5, {32'hA5A50F0F, 2'd0}, last);
    wait_resp_done();

    repeat (3) @(posedge CLK_I);
    #1;
    check("stray_total", stray_cnt, 1);
    check("tx_queue_empty", tx_exp_q.size(), 0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
